imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Registered, flow-controlled immediate generator for the decode stage of the pipelined RV32/RV64 core.
- Takes an instruction word plus its PC and produces a sign-/zero-extended XLEN-wide immediate, a format code, an illegal-encoding flag and the PC-relative target `pc + imm`.
- A valid/ready handshake with a 2-entry skid buffer sits in front of the output, so decode can stall without losing instructions.
- Successor to the combinational 32-bit immediate generator: adds width generalisation, shift-amount handling, illegal detection, target adder and buffering.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- RV64_W, 0, when 1 and XLEN=64, opcode 0011011 (OP-IMM-32) is decoded as I-type/shift; when 0 it is illegal.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- flush  in  1  synchronous drop of all buffered entries
- in_valid  in  1  upstream holds valid ir/pc
- in_ready  out  1  block can accept this cycle
- ir  in  32  instruction word
- pc  in  XLEN  instruction address
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts output
- imm  out  XLEN  generated immediate
- fmt  out  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=SHAMT
- target  out  XLEN  (pc + imm) mod 2^XLEN
- illegal  out  1  encoding not recognised

Behaviour:
- Reset while rst_n=0: out_valid=0, imm/target/fmt/illegal=0, both buffer entries invalid, in_ready=1. Reset mid-operation discards in-flight entries with no output.
- Decode table (ir[6:0]); sign bit is always ir[31], sign-extended to XLEN:
  - 0010011 / 0000011 / 1100111: I-type.
  - 0010011 with funct3 001 or 101: SHAMT, zero-extended. XLEN=32 uses ir[24:20]; XLEN=64 uses ir[25:20]. funct7/funct6 bits are excluded.
  - 0100011: S-type.
  - 1100011: B-type, bit0=0.
  - 0110111 / 0010111: U-type {ir[31:12], 12'b0}, sign-extended above bit 31.
  - 1101111: J-type, bit0=0.
  - 0011011 when RV64_W=1: I or SHAMT, using ir[24:20] only.
- Any other opcode, or ir[1:0]!=2'b11: illegal=1, fmt=0, imm=I-type decode.
- target is computed for every entry; the consumer uses it only for B/J/AUIPC.
- Buffer: output register (OR) plus skid register (SR). in_ready = !SR.valid, driven from a register with no combinational path from out_ready.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Cycle behaviour:
  - Accept with OR empty, or OR popped this cycle and SR empty: entry loads OR; visible next cycle (latency 1).
  - Accept while OR is held (not popped): entry loads SR; in_ready=0 next cycle.
  - Pop with SR valid: SR moves to OR; in_ready=1 next cycle.
  - Simultaneous pop and accept with SR valid cannot occur, because in_ready=0.
- Strict FIFO order. No entry is dropped or duplicated except by flush or reset.
- flush=1: both entries invalidated at the next edge, out_valid=0, in_ready=1. flush has priority over a same-cycle accept, which is discarded.
- Output fields are stable while out_valid=1 and out_ready=0.

Test Plan:
- XLEN=32, pc=0, ir=0xFFF00093 (addi -1) -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=0, illegal=0.
- ir=0xFE20AE23 (sw -4) -> imm=0xFFFFFFFC, fmt=1.
- pc=0x100, ir=0xFE000CE3 (beq -8) -> imm=0xFFFFFFF8, target=0x000000F8, fmt=2.
- pc=0x1000, ir=0x0010006F (jal +2048) -> imm=0x800, target=0x1800, fmt=4.
- Shifts: ir=0x01F09093 (slli 31) -> imm=0x1F, fmt=5; ir=0x4030D093 (srai 3) -> imm=0x3, not 0x403. ir=0x00000000 -> illegal=1.
- Backpressure: out_ready=0, drive 3 back-to-back instructions A/B/C.
  - Expected: A and B accepted, in_ready=0 from the cycle after B.
  - Expected: out_ready=1 then yields A, B, C in order with no gaps after the first.
- Reset and flush, both applied with 2 entries buffered:
  - rst_n low asynchronously mid-cycle -> out_valid=0 immediately.
  - flush -> out_valid=0 next cycle, in_ready=1.
- XLEN=64: ir=0x03F09093 (slli 63) -> imm=0x3F. ir=0x800000B7 (lui) -> imm=0xFFFFFFFF80000000.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//
// Registered, flow-controlled immediate generator for the decode stage of the
// pipelined RV32/RV64 core. Each accepted instruction word is decoded into a
// sign- or zero-extended XLEN-wide immediate. The block also produces a format
// code, an illegal-encoding flag and the PC-relative target (pc + imm). A
// two-entry buffer (output register + skid register) sits in front of the
// outputs, so decode can stall without losing instructions.
//
// Parameters
//   XLEN     datapath width, 32 or 64
//   RV64_W   1 (with XLEN=64): decode OP-IMM-32 (0011011) as I/SHAMT
//            0: treat OP-IMM-32 as illegal
//
// Ports
//   clk        in   1     clock, rising edge
//   rst_n      in   1     asynchronous reset, active-low
//   flush      in   1     synchronous drop of all buffered entries
//   in_valid   in   1     upstream presents a valid ir/pc
//   in_ready   out  1     block can accept this cycle (registered)
//   ir         in   32    instruction word
//   pc         in   XLEN  instruction address
//   out_valid  out  1     output entry valid
//   out_ready  in   1     downstream accepts the output entry
//   imm        out  XLEN  generated immediate
//   fmt        out  3     0=I 1=S 2=B 3=U 4=J 5=SHAMT
//   target     out  XLEN  (pc + imm) mod 2^XLEN
//   illegal    out  1     encoding not recognised
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter bit RV64_W = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     ir,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] target,
    output logic            illegal
);

    // Format codes
    localparam logic [2:0] FMT_I     = 3'd0;
    localparam logic [2:0] FMT_S     = 3'd1;
    localparam logic [2:0] FMT_B     = 3'd2;
    localparam logic [2:0] FMT_U     = 3'd3;
    localparam logic [2:0] FMT_J     = 3'd4;
    localparam logic [2:0] FMT_SHAMT = 3'd5;

    // Major opcodes that carry an immediate
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    // OP-IMM-32 exists only on RV64 builds that enable the W instructions
    localparam bit W_EN = (XLEN == 64) && (RV64_W == 1'b1);

    // Buffered entry layout: {imm, target, fmt, illegal}
    localparam int EW = 2 * XLEN + 4;

    // -----------------------------------------------------------------------
    // Immediate candidates, one per format
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_sh;
    logic [XLEN-1:0] w_imm_shw;
    logic [5:0]      w_shamt;
    logic            w_is_shift;

    assign w_imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
    assign w_imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
    assign w_imm_b = {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
    // U-type: ir[31] sits at bit 31 and is replicated above it on RV64
    assign w_imm_u = {{(XLEN-31){ir[31]}}, ir[30:12], 12'b0};
    assign w_imm_j = {{(XLEN-20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

    // Shift amounts are unsigned and exclude the funct7/funct6 field, so
    // srai's 0x400 marker bit never leaks into the immediate.
    assign w_shamt   = (XLEN == 64) ? ir[25:20] : {1'b0, ir[24:20]};
    assign w_imm_sh  = {{(XLEN-6){1'b0}}, w_shamt};
    // Word shifts are always 5-bit, even on RV64
    assign w_imm_shw = {{(XLEN-5){1'b0}}, ir[24:20]};

    // funct3 001 (sll*) and 101 (srl*/sra*) are the immediate shifts
    assign w_is_shift = (ir[14:12] == 3'b001) || (ir[14:12] == 3'b101);

    // -----------------------------------------------------------------------
    // Format select
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_illegal;
    logic [XLEN-1:0] w_target;
    logic [EW-1:0]   w_entry;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        w_imm     = w_imm_i;
        w_fmt     = FMT_I;
        w_illegal = 1'b0;
        // Every legal opcode ends in 2'b11, so a compressed or otherwise
        // malformed word (ir[1:0] != 2'b11) always lands in the default arm.
        case (ir[6:0])
            OPC_OP_IMM: begin
                if (w_is_shift) begin
                    w_imm = w_imm_sh;
                    w_fmt = FMT_SHAMT;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                w_imm = w_imm_i;
                w_fmt = FMT_I;
            end
            OPC_STORE: begin
                w_imm = w_imm_s;
                w_fmt = FMT_S;
            end
            OPC_BRANCH: begin
                w_imm = w_imm_b;
                w_fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_imm = w_imm_u;
                w_fmt = FMT_U;
            end
            OPC_JAL: begin
                w_imm = w_imm_j;
                w_fmt = FMT_J;
            end
            OPC_OP_IMM_32: begin
                if (W_EN) begin
                    if (w_is_shift) begin
                        w_imm = w_imm_shw;
                        w_fmt = FMT_SHAMT;
                    end
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // The target is computed for every entry. Only B/J/AUIPC consumers use it.
    assign w_target = pc + w_imm;
    assign w_entry  = {w_imm, w_target, w_fmt, w_illegal};

    // -----------------------------------------------------------------------
    // Two-entry buffer: output register (OR) plus skid register (SR)
    // -----------------------------------------------------------------------
    logic          r_or_valid;
    logic [EW-1:0] r_or_data;
    logic          r_sr_valid;
    logic [EW-1:0] r_sr_data;
    logic          w_accept;
    logic          w_pop;

    // in_ready depends only on a flop, never on out_ready, so the upstream
    // handshake has no combinational path through this block.
    assign in_ready = ~r_sr_valid;
    assign w_accept = in_valid & in_ready;
    assign w_pop    = r_or_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: payload registers are reset as well as the valid bits,
            // because imm/target/fmt/illegal must read zero during reset.
            r_or_valid <= 1'b0;
            r_or_data  <= '0;
            r_sr_valid <= 1'b0;
            r_sr_data  <= '0;
        end else if (flush) begin
            // A flush wins over a same-cycle accept, which is dropped
            r_or_valid <= 1'b0;
            r_sr_valid <= 1'b0;
        end else if (w_pop) begin
            if (r_sr_valid) begin
                // The skid entry moves up. No accept can happen in this
                // cycle, because in_ready was low while SR was full.
                // NOTE: non-blocking assignments let OR read SR's old value
                // in the same edge that clears SR, independent of order.
                r_or_data  <= r_sr_data;
                r_sr_valid <= 1'b0;
            end else if (w_accept) begin
                // Back-to-back streaming: OR drains and refills in one edge
                r_or_data  <= w_entry;
            end else begin
                r_or_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_or_valid) begin
                r_or_valid <= 1'b1;
                r_or_data  <= w_entry;
            end else begin
                // OR is held by the consumer, so the new entry parks in SR
                r_sr_valid <= 1'b1;
                r_sr_data  <= w_entry;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs come straight from OR, so they are stable while stalled
    // -----------------------------------------------------------------------
    assign out_valid = r_or_valid;
    assign imm       = r_or_data[EW-1 -: XLEN];
    assign target    = r_or_data[XLEN+3 : 4];
    assign fmt       = r_or_data[3:1];
    assign illegal   = r_or_data[0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Self-checking bench for imm_gen_pipe. It drives two instances: one with
// XLEN=32 and RV64_W=0, and one with XLEN=64 and RV64_W=1. A table of directed
// vectors holds hand-computed expected values, and hand-written sequences
// cover backpressure, asynchronous reset and flush.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    // XLEN=32 instance
    logic        v32_in_valid  = 1'b0;
    logic        v32_in_ready;
    logic [31:0] v32_ir        = '0;
    logic [31:0] v32_pc        = '0;
    logic        v32_out_valid;
    logic        v32_out_ready = 1'b1;
    logic [31:0] v32_imm;
    logic [2:0]  v32_fmt;
    logic [31:0] v32_target;
    logic        v32_illegal;

    // XLEN=64 instance
    logic        v64_in_valid  = 1'b0;
    logic        v64_in_ready;
    logic [31:0] v64_ir        = '0;
    logic [63:0] v64_pc        = '0;
    logic        v64_out_valid;
    logic        v64_out_ready = 1'b1;
    logic [63:0] v64_imm;
    logic [2:0]  v64_fmt;
    logic [63:0] v64_target;
    logic        v64_illegal;

    imm_gen_pipe #(.XLEN(32), .RV64_W(1'b0)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (v32_in_valid),
        .in_ready  (v32_in_ready),
        .ir        (v32_ir),
        .pc        (v32_pc),
        .out_valid (v32_out_valid),
        .out_ready (v32_out_ready),
        .imm       (v32_imm),
        .fmt       (v32_fmt),
        .target    (v32_target),
        .illegal   (v32_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .RV64_W(1'b1)) u_dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (v64_in_valid),
        .in_ready  (v64_in_ready),
        .ir        (v64_ir),
        .pc        (v64_pc),
        .out_valid (v64_out_valid),
        .out_ready (v64_out_ready),
        .imm       (v64_imm),
        .fmt       (v64_fmt),
        .target    (v64_target),
        .illegal   (v64_illegal)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is64;
        logic [31:0] ir;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [63:0] target;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    initial begin
        logic        a_valid;
        logic [63:0] a_imm;
        logic [2:0]  a_fmt;
        logic        a_ill;
        logic [63:0] a_target;

        //            is64  ir             pc                      imm                     fmt   ill   target
        vecs[0]  = '{1'b0, 32'hFFF00093, 64'h0,                  64'hFFFFFFFF,           3'd0, 1'b0, 64'hFFFFFFFF};          // addi -1
        vecs[1]  = '{1'b0, 32'hFE20AE23, 64'h0,                  64'hFFFFFFFC,           3'd1, 1'b0, 64'hFFFFFFFC};          // sw -4
        vecs[2]  = '{1'b0, 32'hFE000CE3, 64'h100,                64'hFFFFFFF8,           3'd2, 1'b0, 64'h000000F8};          // beq -8
        vecs[3]  = '{1'b0, 32'h0010006F, 64'h1000,               64'h800,                3'd4, 1'b0, 64'h1800};              // jal +2048
        vecs[4]  = '{1'b0, 32'h01F09093, 64'h0,                  64'h1F,                 3'd5, 1'b0, 64'h1F};                // slli 31
        vecs[5]  = '{1'b0, 32'h4030D093, 64'h0,                  64'h3,                  3'd5, 1'b0, 64'h3};                 // srai 3
        vecs[6]  = '{1'b0, 32'h00000000, 64'h20,                 64'h0,                  3'd0, 1'b1, 64'h20};                // all-zero word
        vecs[7]  = '{1'b0, 32'h12345037, 64'h0,                  64'h12345000,           3'd3, 1'b0, 64'h12345000};          // lui
        vecs[8]  = '{1'b0, 32'h80000017, 64'h10,                 64'h80000000,           3'd3, 1'b0, 64'h80000010};          // auipc
        vecs[9]  = '{1'b0, 32'h80002003, 64'h0,                  64'hFFFFF800,           3'd0, 1'b0, 64'hFFFFF800};          // lw -2048
        vecs[10] = '{1'b0, 32'h7FF00067, 64'h4,                  64'h7FF,                3'd0, 1'b0, 64'h803};               // jalr +2047
        vecs[11] = '{1'b0, 32'h0000007F, 64'h8,                  64'h0,                  3'd0, 1'b1, 64'h8};                 // unknown opcode
        vecs[12] = '{1'b0, 32'hFFF00091, 64'h0,                  64'hFFFFFFFF,           3'd0, 1'b1, 64'hFFFFFFFF};          // ir[1:0]=01
        vecs[13] = '{1'b0, 32'h0010809B, 64'h0,                  64'h1,                  3'd0, 1'b1, 64'h1};                 // addiw on RV32
        vecs[14] = '{1'b0, 32'h0010006F, 64'hFFFFFFF0,           64'h800,                3'd4, 1'b0, 64'h7F0};               // target wraps
        vecs[15] = '{1'b0, 32'h00001863, 64'h200,                64'h10,                 3'd2, 1'b0, 64'h210};               // bne +16
        vecs[16] = '{1'b1, 32'h03F09093, 64'h0,                  64'h3F,                 3'd5, 1'b0, 64'h3F};                // slli 63
        vecs[17] = '{1'b1, 32'h800000B7, 64'h0,                  64'hFFFFFFFF80000000,   3'd3, 1'b0, 64'hFFFFFFFF80000000};  // lui RV64
        vecs[18] = '{1'b1, 32'h0010809B, 64'h0,                  64'h1,                  3'd0, 1'b0, 64'h1};                 // addiw
        vecs[19] = '{1'b1, 32'h0210909B, 64'h0,                  64'h1,                  3'd5, 1'b0, 64'h1};                 // slliw drops bit25
        vecs[20] = '{1'b1, 32'hFFF00093, 64'h10,                 64'hFFFFFFFFFFFFFFFF,   3'd0, 1'b0, 64'hF};                 // addi -1 RV64
        vecs[21] = '{1'b1, 32'h4230D093, 64'h0,                  64'h23,                 3'd5, 1'b0, 64'h23};                // srai 35

        // ---------------- reset state ----------------
        #2;
        check("reset out_valid", {63'b0, v32_out_valid}, 64'd0);
        check("reset in_ready",  {63'b0, v32_in_ready},  64'd1);
        check("reset imm",       {32'b0, v32_imm},       64'd0);
        check("reset target",    {32'b0, v32_target},    64'd0);
        check("reset fmt",       {61'b0, v32_fmt},       64'd0);
        check("reset illegal",   {63'b0, v32_illegal},   64'd0);
        check("reset out_valid64", {63'b0, v64_out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table-driven decode ----------------
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if (vecs[i].is64) begin
                v64_in_valid = 1'b1;
                v64_ir       = vecs[i].ir;
                v64_pc       = vecs[i].pc;
            end else begin
                v32_in_valid = 1'b1;
                v32_ir       = vecs[i].ir;
                v32_pc       = vecs[i].pc[31:0];
            end
            @(posedge clk);
            #1;
            if (vecs[i].is64) begin
                a_valid  = v64_out_valid;
                a_imm    = v64_imm;
                a_fmt    = v64_fmt;
                a_ill    = v64_illegal;
                a_target = v64_target;
            end else begin
                a_valid  = v32_out_valid;
                a_imm    = {32'b0, v32_imm};
                a_fmt    = v32_fmt;
                a_ill    = v32_illegal;
                a_target = {32'b0, v32_target};
            end
            check($sformatf("v%0d out_valid", i), {63'b0, a_valid}, 64'd1);
            check($sformatf("v%0d imm", i),       a_imm,            vecs[i].imm);
            check($sformatf("v%0d fmt", i),       {61'b0, a_fmt},   {61'b0, vecs[i].fmt});
            check($sformatf("v%0d illegal", i),   {63'b0, a_ill},   {63'b0, vecs[i].ill});
            check($sformatf("v%0d target", i),    a_target,         vecs[i].target);
            v32_in_valid = 1'b0;
            v64_in_valid = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        check("drain out_valid", {63'b0, v32_out_valid}, 64'd0);

        // ---------------- backpressure: A, B, C with out_ready=0 ----------------
        v32_pc        = 32'h0;
        v32_out_ready = 1'b0;
        v32_in_valid  = 1'b1;
        v32_ir        = 32'h00100093;  // A: addi 1
        @(posedge clk); #1;
        check("bp A visible",      {32'b0, v32_imm},      64'd1);
        check("bp in_ready after A", {63'b0, v32_in_ready}, 64'd1);
        @(negedge clk);
        v32_ir = 32'h00200093;         // B: addi 2
        @(posedge clk); #1;
        check("bp in_ready after B", {63'b0, v32_in_ready}, 64'd0);
        check("bp A held",         {32'b0, v32_imm},      64'd1);
        @(negedge clk);
        v32_ir = 32'h00300093;         // C: addi 3, must wait
        @(posedge clk); #1;
        check("bp C blocked",      {63'b0, v32_in_ready}, 64'd0);
        check("bp A still held",   {32'b0, v32_imm},      64'd1);
        @(negedge clk);
        v32_out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp B valid",        {63'b0, v32_out_valid}, 64'd1);
        check("bp B order",        {32'b0, v32_imm},       64'd2);
        check("bp in_ready after skid pop", {63'b0, v32_in_ready}, 64'd1);
        @(posedge clk); #1;
        check("bp C valid",        {63'b0, v32_out_valid}, 64'd1);
        check("bp C order",        {32'b0, v32_imm},       64'd3);
        @(negedge clk);
        v32_in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp drained",        {63'b0, v32_out_valid}, 64'd0);

        // ---------------- async reset with two entries buffered ----------------
        @(negedge clk);
        v32_out_ready = 1'b0;
        v32_in_valid  = 1'b1;
        v32_ir        = 32'h00500093;
        @(negedge clk);
        v32_ir        = 32'h00600093;
        @(negedge clk);
        v32_in_valid  = 1'b0;
        check("rst pre full",      {63'b0, v32_in_ready}, 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst out_valid",     {63'b0, v32_out_valid}, 64'd0);
        check("rst in_ready",      {63'b0, v32_in_ready},  64'd1);
        check("rst imm cleared",   {32'b0, v32_imm},       64'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        v32_out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst no ghost",      {63'b0, v32_out_valid}, 64'd0);

        // ---------------- flush with two entries buffered ----------------
        @(negedge clk);
        v32_out_ready = 1'b0;
        v32_in_valid  = 1'b1;
        v32_ir        = 32'h00700093;
        @(negedge clk);
        v32_ir        = 32'h00800093;
        @(negedge clk);
        check("flush pre full",    {63'b0, v32_in_ready}, 64'd0);
        flush  = 1'b1;
        v32_ir = 32'h00900093;         // offered alongside flush, must vanish
        @(posedge clk); #1;
        check("flush out_valid",   {63'b0, v32_out_valid}, 64'd0);
        check("flush in_ready",    {63'b0, v32_in_ready},  64'd1);
        @(negedge clk);
        flush         = 1'b0;
        v32_in_valid  = 1'b0;
        v32_out_ready = 1'b1;
        @(posedge clk); #1;
        check("flush accept dropped", {63'b0, v32_out_valid}, 64'd0);
        @(negedge clk);
        v32_in_valid = 1'b1;
        v32_ir       = 32'h00A00093;
        @(posedge clk); #1;
        check("post-flush valid",  {63'b0, v32_out_valid}, 64'd1);
        check("post-flush imm",    {32'b0, v32_imm},       64'd10);
        @(negedge clk);
        v32_in_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
